// File: rtl/ibis_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ibis_pkg
// Brief   : Shared types and defaults for the ibis voice blocks.
// Revision: 1.0 - initial stepper state type and step width default
// ============================================================================
package ibis_pkg;

  localparam int IBIS_STEP_BITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } ibis_stepper_state_t;

endpackage
`default_nettype wire

// File: rtl/ibis_step_event_slot.sv
`default_nettype none
// ============================================================================
// Module  : ibis_step_event_slot
// Brief   : One-entry valid/ready holding register for step events.
// Revision: 1.0 - initial release
// ============================================================================
module ibis_step_event_slot #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             event_req,
  input  logic [WIDTH-1:0] event_data,
  input  logic             flush,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             load,
  output logic             drop,
  output logic             overrun
);

  // A flush both empties the slot and swallows any event offered with it.
  assign load    = event_req & ~flush & (~valid | ready);
  assign overrun = event_req & ~flush & valid & ~ready;
  assign drop    = event_req & ~load;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= event_data;
    end else if (valid & ready) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ibis_wave_stepper.sv
`default_nettype none
// ============================================================================
// Module  : ibis_wave_stepper
// Brief   : Wavetable step sequencer driving phase_reset of the accumulator.
//           Optional overrun counter: IBIS_WAVE_STEPPER_OVERRUN_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ibis_wave_stepper
  import ibis_pkg::*;
#(
  parameter int STEP_BITS = IBIS_STEP_BITS
`ifdef IBIS_WAVE_STEPPER_OVERRUN_EN
  ,
  parameter int OVR_WIDTH = 8
`endif
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 enable,
  input  logic                 key_on,
  input  logic                 key_off,
  input  logic [STEP_BITS-1:0] loop_start,
  input  logic [STEP_BITS-1:0] loop_end,
  input  logic                 phase_is_zero,
  output logic                 phase_reset,
  output logic [STEP_BITS-1:0] step_index,
  output logic                 step_valid,
  input  logic                 step_ready,
  output logic                 active,
  output logic [STEP_BITS-1:0] DEBUG_step
`ifdef IBIS_WAVE_STEPPER_OVERRUN_EN
  ,
  output logic [OVR_WIDTH-1:0] overrun_count
`endif
);

  ibis_stepper_state_t  state_q, state_d;
  logic [STEP_BITS-1:0] step_q, step_d;
  logic [STEP_BITS-1:0] step_inc;
  logic [STEP_BITS-1:0] event_data;
  logic                 event_req;
  logic                 flush;
  logic                 slot_load, slot_drop, slot_overrun;

  assign step_inc = (step_q == loop_end) ? loop_start : step_q + STEP_BITS'(1);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    phase_reset = 1'b0;
    event_req   = 1'b0;
    event_data  = step_q;
    flush       = 1'b0;

    case (state_q)
      IDLE: begin
      end
      PRIME: begin
        phase_reset = enable;
        event_req   = enable;
        if (enable) state_d = RUN;
      end
      RUN: begin
        phase_reset = enable & phase_is_zero;
        if (enable & phase_is_zero) begin
          event_req  = 1'b1;
          event_data = step_inc;
          step_d     = step_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    // Key events override the step; the flush makes the slot drop its event.
    if (enable & key_on) begin
      state_d = PRIME;
      step_d  = loop_start;
      flush   = 1'b1;
    end else if (enable & key_off & (state_q != IDLE)) begin
      state_d = IDLE;
      step_d  = step_q;
      flush   = 1'b1;
    end
  end

  assign active     = (state_q != IDLE);
  assign DEBUG_step = step_q;

  ibis_step_event_slot #(
    .WIDTH (STEP_BITS)
  ) u_slot (
    .clk        (aclk),
    .rst        (areset),
    .event_req  (event_req),
    .event_data (event_data),
    .flush      (flush),
    .ready      (step_ready),
    .valid      (step_valid),
    .data       (step_index),
    .load       (slot_load),
    .drop       (slot_drop),
    .overrun    (slot_overrun)
  );

`ifdef IBIS_WAVE_STEPPER_OVERRUN_EN
  logic unused_slot_flags;
  assign unused_slot_flags = slot_load ^ slot_drop;

  always_ff @(posedge aclk) begin
    if (areset) begin
      overrun_count <= '0;
    end else if (slot_overrun && (overrun_count != {OVR_WIDTH{1'b1}})) begin
      overrun_count <= overrun_count + OVR_WIDTH'(1);
    end
  end
`else
  logic unused_slot_flags;
  assign unused_slot_flags = slot_load ^ slot_drop ^ slot_overrun;
`endif

endmodule
`default_nettype wire

// File: doc/ibis_wave_stepper.md
# ibis_wave_stepper

Wavetable step sequencer sitting directly downstream of `ibis_phase_accumulator`. It watches the accumulator's `phase_is_zero` and drives its `phase_reset` back, so each countdown period becomes one wavetable step. On every step it advances a looping step index and offers it to the sample-fetch stage over a valid/ready handshake. Key-on/key-off control start, retrigger and stop.

## Interface
- `STEP_BITS`, 5, width of step index (wavetable of 2^STEP_BITS entries)
- `OVR_WIDTH`, 8, width of overrun counter (only with macro)

- `aclk` in 1: clock
- `areset` in 1: synchronous, active-high reset
- `enable` in 1: tick, the same strobe that drives the accumulator's `enable`
- `key_on` in 1: start or retrigger, sampled only when `enable` is high
- `key_off` in 1: stop, sampled only when `enable` is high
- `loop_start` in STEP_BITS: first step and loop-back target
- `loop_end` in STEP_BITS: last step before loop-back
- `phase_is_zero` in 1: from the accumulator
- `phase_reset` out 1: to the accumulator; combinational
- `step_index` out STEP_BITS: event payload, stable while `step_valid & !step_ready`
- `step_valid` out 1: event offered
- `step_ready` in 1: event accepted by sample fetch
- `active` out 1: state is not IDLE
- `DEBUG_step` out STEP_BITS: internal step counter
- `overrun_count` out OVR_WIDTH: only with `IBIS_WAVE_STEPPER_OVERRUN_EN`

## Operation
- States are IDLE, PRIME and RUN. All state and counter updates require `enable`. The handshake side (acceptance, clearing `step_valid`) ignores `enable`.
- **IDLE**
  - `key_on` loads `loop_start` into the step counter and moves to PRIME.
  - `key_off` is ignored.
- **PRIME**
  - `phase_reset = enable`, so the accumulator reloads its held value.
  - On that enabled edge, emit an event carrying the counter value (`loop_start`) and move to RUN.
- **RUN**
  - `phase_reset = enable & phase_is_zero`.
  - On an enabled edge with `phase_is_zero` high:
    - Advance the counter: if it equals `loop_end`, load `loop_start`; otherwise add 1 modulo 2^STEP_BITS.
    - Emit an event carrying the new value.
  - If `loop_start == loop_end`, every event repeats that value.
  - If `loop_end < loop_start`, the counter wraps through 2^STEP_BITS-1 to 0 before reaching `loop_end`.
- **Key priority, evaluated each enabled edge in any state**
  - `key_on` (even together with `key_off`) forces PRIME, reloads `loop_start` and discards any pending event.
  - `key_off` alone in PRIME or RUN moves to IDLE and clears `step_valid`.
  - A step due on the same edge as a key event is dropped.
- **Event slot (one entry)**
  - An event loads if `!step_valid | step_ready`.
  - Otherwise the event is dropped, `step_index` stays stable, the internal counter still advances, and an overrun is recorded.
  - `step_valid` clears on `step_valid & step_ready` unless a new event loads on the same edge.
- If the accumulator's held value is 0, `phase_is_zero` stays high and one step occurs every enabled cycle. This is legal.

## Timing
- Reset values:
  - state = IDLE
  - `DEBUG_step` = 0, `step_index` = 0
  - `step_valid` = 0, `active` = 0
  - `phase_reset` = 0
  - `overrun_count` = 0
- `areset` mid-operation wins over everything, drops any pending event, and leaves the accumulator untouched.
- Latency:
  - `key_on` at enabled edge N: PRIME from N+1.
  - `phase_reset` is high during the next enabled cycle, edge M.
  - `step_valid` rises after M.
  - Minimum is 2 clocks when `enable` is held high.
- Step latency: `phase_is_zero` high in an enabled cycle gives `phase_reset` in the same cycle, with `step_valid` and the new `step_index` on the next clock.
- `phase_reset` is never asserted in IDLE or while `enable` is low.

## Configuration
- `IBIS_WAVE_STEPPER_OVERRUN_EN` defined:
  - The `overrun_count` port exists.
  - It increments on each dropped step event and saturates at all-ones.
  - It clears on `areset` only.
- Macro undefined: the port and counter are absent; dropped events are silently discarded.

## Structure
- Add to the shared `ibis_pkg`:
  - the state enum `ibis_stepper_state_t` (IDLE, PRIME, RUN)
  - the default `IBIS_STEP_BITS` = 5
- One sub-module, `ibis_step_event_slot`: a one-entry valid/ready holding register with `load`, `drop` and `overrun` outputs. The FSM and step counter stay in the top module.

## Test plan
- Start: reset; `loop_start`=3, `loop_end`=5, `enable`=1, `key_on` pulse; model `phase_is_zero` high every 4th cycle; `step_ready`=1 -> `phase_reset` in PRIME; events 3,4,5,3,4, each one clock after `phase_is_zero`.
- Wrap: `loop_start`=30, `loop_end`=1, `STEP_BITS`=5 -> events 30,31,0,1,30.
- Backpressure: `step_ready`=0 through 3 steps -> `step_index` holds first value; 2 drops; `overrun_count`=2 (macro on); `DEBUG_step` keeps advancing.
- Key conflict: `key_on` & `key_off` together in RUN -> PRIME; then event `loop_start`; `key_off` alone -> IDLE, `step_valid`=0, `phase_reset` stays 0 thereafter.
- Enable gating: `enable`=0 with `phase_is_zero`=1 -> no `phase_reset`, no advance; `step_ready` still clears `step_valid`.
- Mid-run `areset` with pending event -> all outputs at reset values next cycle.
